seq_tx_8: RTL and testbench

SEQ_TX_8 -- requirements
Module: seq_tx_8

---
 rtl/seq_tx_8.sv | 142 ++++++++++++++
 tb/tb_seq_tx_8.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_tx_8.sv
// seq_tx_8 -- serial pattern transmitter.
//
// Holds an 8-bit pattern and shifts it out LSB first on dout. Each bit is
// held for bit_div+1 clocks, and the whole pattern is sent rep_cnt+1 times
// back to back. A one-cycle done pulse follows a frame that completes.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   load        capture pattern_in into the pattern register (IDLE only)
//   pattern_in  pattern to transmit, bit 0 first
//   start       begin a transmission (IDLE only, not queued)
//   abort       cancel an active transmission (SHIFT only)
//   rep_cnt     additional repetitions, latched at start
//   bit_div     bit period minus one, latched at start
//   dout        serial data (registered)
//   dout_valid  high while dout carries a pattern bit (registered)
//   busy        high whenever the FSM is not IDLE (registered)
//   done        one-cycle completion pulse (registered)
//
// Handshake: load, start and abort are plain level strobes sampled on
// every rising edge. There is no valid/ready pairing; a strobe that
// arrives in a state that does not accept it is dropped, not queued.

module seq_tx_8 #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       rep_cnt,
    input  logic [DIV_W-1:0] bit_div,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_SHIFT = 3'b010,
        S_DONE  = 3'b100
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pattern;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_lat;
    logic [IDX_W-1:0] bit_idx;
    logic [3:0]       rep_left;
    logic [IDX_W-1:0] idx_nxt;

    // Bit index wraps modulo WIDTH naturally through its width.
    assign idx_nxt = bit_idx + 1'b1;

    // Outputs are registered, so each transition loads the output values
    // that belong to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pattern    <= '0;
            div_cnt    <= '0;
            div_lat    <= '0;
            bit_idx    <= '0;
            rep_left   <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (load)
                        pattern <= pattern_in;
                    if (start) begin
                        state      <= S_SHIFT;
                        rep_left   <= rep_cnt;
                        div_lat    <= bit_div;
                        bit_idx    <= '0;
                        div_cnt    <= '0;
                        // A simultaneous load must be the pattern sent, so
                        // take bit 0 straight from the input in that case.
                        dout       <= load ? pattern_in[0] : pattern[0];
                        dout_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        dout       <= 1'b0;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (div_cnt == div_lat) begin
                        div_cnt <= '0;
                        if (bit_idx == IDX_W'(WIDTH - 1)) begin
                            if (rep_left != 4'd0) begin
                                // Next repetition starts with no gap cycle.
                                rep_left <= rep_left - 4'd1;
                                bit_idx  <= '0;
                                dout     <= pattern[0];
                            end else begin
                                state      <= S_DONE;
                                dout       <= 1'b0;
                                dout_valid <= 1'b0;
                                done       <= 1'b1;
                            end
                        end else begin
                            bit_idx <= idx_nxt;
                            dout    <= pattern[idx_nxt];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state      <= S_IDLE;
                    dout       <= 1'b0;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_tx_8.sv
// Directed testbench for seq_tx_8. Expected bit streams come from the
// hand-written pattern constants below; outputs are sampled 1 ns after
// each rising edge and compared as {dout, dout_valid, busy, done}.

module tb_seq_tx_8;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [7:0] pattern_in;
    logic       start;
    logic       abort;
    logic [3:0] rep_cnt;
    logic [3:0] bit_div;
    logic       dout;
    logic       dout_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    seq_tx_8 #(.WIDTH(8), .DIV_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .pattern_in (pattern_in),
        .start      (start),
        .abort      (abort),
        .rep_cnt    (rep_cnt),
        .bit_div    (bit_div),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Issue start (optionally with load) for one edge; returns 1 ns after
    // the start edge, i.e. in the cycle where bit 0 should be visible.
    task automatic start_frame(input logic load_en, input logic [7:0] pat,
                               input logic [3:0] div, input logic [3:0] reps);
        load       = load_en;
        pattern_in = pat;
        start      = 1'b1;
        bit_div    = div;
        rep_cnt    = reps;
        tick();
        load  = 1'b0;
        start = 1'b0;
    endtask

    // Check a whole frame from the first bit through the done pulse and
    // the return to idle. At cycle 'poke' (if >= 0) a load of 8'hFF, a
    // start and new divider/repeat values are driven mid-frame; all of
    // them must be ignored.
    task automatic expect_frame(input string tag, input logic [7:0] exp_pat,
                                input int div, input int reps, input int poke);
        int   total;
        logic exp_bit;
        total = 8 * (div + 1) * (reps + 1);
        for (int k = 0; k < total; k++) begin
            exp_bit = exp_pat[(k / (div + 1)) % 8];
            check($sformatf("%s k=%0d", tag, k),
                  {28'd0, dout, dout_valid, busy, done}, {28'd0, exp_bit, 3'b110});
            if (k == poke) begin
                load       = 1'b1;
                pattern_in = 8'hFF;
                start      = 1'b1;
                bit_div    = 4'd0;
                rep_cnt    = 4'd0;
            end else begin
                load  = 1'b0;
                start = 1'b0;
            end
            tick();
        end
        load  = 1'b0;
        start = 1'b0;
        check($sformatf("%s done", tag), {28'd0, dout, dout_valid, busy, done}, 32'b0011);
        tick();
        check($sformatf("%s idle", tag), {28'd0, dout, dout_valid, busy, done}, 32'b0000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pat_c5;
        logic [7:0] pat_5a;
        pat_c5 = 8'hC5;   // bits LSB first: 1,0,1,0,0,0,1,1
        pat_5a = 8'h5A;   // bits LSB first: 0,1,0,1,1,0,1,0

        rst_n      = 1'b0;
        load       = 1'b0;
        pattern_in = 8'h00;
        start      = 1'b0;
        abort      = 1'b0;
        rep_cnt    = 4'd0;
        bit_div    = 4'd0;
        #3;
        check("reset outputs", {28'd0, dout, dout_valid, busy, done}, 32'b0000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // B4 sent once at one clock per bit: 0,0,1,0,1,1,0,1, done at +9.
        load       = 1'b1;
        pattern_in = 8'hB4;
        tick();
        load = 1'b0;
        check("idle after load", {28'd0, dout, dout_valid, busy, done}, 32'b0000);
        start_frame(1'b0, 8'h00, 4'd0, 4'd0);
        expect_frame("b4", 8'hB4, 0, 0, -1);

        // 81 held 3 clocks per bit, sent twice (48 valid cycles). Divider
        // and repeat inputs change mid-frame and must not matter.
        load       = 1'b1;
        pattern_in = 8'h81;
        tick();
        start_frame(1'b0, 8'h00, 4'd2, 4'd1);
        expect_frame("81x2", 8'h81, 2, 1, 10);

        // Simultaneous load and start: 0F goes out as 1,1,1,1,0,0,0,0.
        start_frame(1'b1, 8'h0F, 4'd0, 4'd0);
        expect_frame("0f same", 8'h0F, 0, 0, -1);

        // Mid-frame load FF and start are ignored; pattern stays 3C.
        start_frame(1'b1, 8'h3C, 4'd1, 4'd0);
        expect_frame("3c poke", 8'h3C, 1, 0, 5);
        start_frame(1'b0, 8'h00, 4'd0, 4'd0);
        expect_frame("3c kept", 8'h3C, 0, 0, -1);

        // Abort at bit 3: idle next cycle, no done pulse.
        start_frame(1'b1, pat_c5, 4'd0, 4'd0);
        for (int k = 0; k <= 3; k++) begin
            check($sformatf("abort bit k=%0d", k),
                  {28'd0, dout, dout_valid, busy, done}, {28'd0, pat_c5[k], 3'b110});
            if (k == 3) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        check("abort idle", {28'd0, dout, dout_valid, busy, done}, 32'b0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("abort no done %0d", k), {31'd0, done}, 32'd0);
        end

        // Reset at bit 5 of a repeating frame: outputs clear at once, and
        // the next start sends 00.
        start_frame(1'b1, pat_5a, 4'd0, 4'd2);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rst frame k=%0d", k),
                  {28'd0, dout, dout_valid, busy, done}, {28'd0, pat_5a[k], 3'b110});
            tick();
        end
        check("rst frame k=5", {28'd0, dout, dout_valid, busy, done}, {28'd0, pat_5a[5], 3'b110});
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset", {28'd0, dout, dout_valid, busy, done}, 32'b0000);
        tick();
        tick();
        check("held reset", {28'd0, dout, dout_valid, busy, done}, 32'b0000);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post reset quiet %0d", k), {28'd0, dout, dout_valid, busy, done}, 32'b0000);
        end
        start_frame(1'b0, 8'hFF, 4'd0, 4'd0);
        expect_frame("after reset", 8'h00, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
